debounce: RTL

- Synthesizable debouncer for mechanical button and switch inputs.
- Consumes a raw, bouncy, asynchronous signal and produces a clean level plus single-cycle edge pulses for downstream logic (button-driven TX triggers, counters).
- A transition is accepted only after the input has stayed at its new value for WAIT_TIME_US.

---
 rtl/debounce.sv | 128 ++++++++++++
 1 files changed

// File: rtl/debounce.sv
// Debouncer for mechanical inputs: two-flop synchronizer, stable-time qualifier FSM,
// registered clean level plus single-cycle rise/fall pulses.
module debounce #(
  parameter int unsigned CLK_FREQUENCY = 100_000_000,
  parameter int unsigned WAIT_TIME_US  = 5000
) (
  input  logic clk,
  input  logic rst,
  input  logic sig_in,
  output logic debounce_out,
  output logic rise_pulse,
  output logic fall_pulse
);

  localparam int unsigned WAIT_CLOCKS = CLK_FREQUENCY / 1_000_000 * WAIT_TIME_US;
  localparam int unsigned CNT_W       = (WAIT_CLOCKS > 2) ? $clog2(WAIT_CLOCKS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CLOCKS - 1);

  generate
    if (WAIT_CLOCKS < 2) begin : g_bad_wait
      $error("debounce: WAIT_CLOCKS must be >= 2");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_LOW  = 2'd0,
    ST_L2H  = 2'd1,
    ST_HIGH = 2'd2,
    ST_H2L  = 2'd3
  } state_t;

  logic             r_s1;
  logic             r_s_sync;
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_out;
  logic             r_rise;
  logic             r_fall;

  state_t           w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_out_nxt;
  logic             w_rise_nxt;
  logic             w_fall_nxt;

  // Metastability guard for the asynchronous raw input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1     <= 1'b0;
      r_s_sync <= 1'b0;
    end else begin
      r_s1     <= sig_in;
      r_s_sync <= r_s1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_LOW;
      r_cnt   <= '0;
      r_out   <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_out   <= w_out_nxt;
      r_rise  <= w_rise_nxt;
      r_fall  <= w_fall_nxt;
    end
  end

  // Transition states count stable cycles; any reversion restarts from the settled level.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_rise_nxt  = 1'b0;
    w_fall_nxt  = 1'b0;
    case (r_state)
      ST_LOW: begin
        if (r_s_sync) begin
          w_state_nxt = ST_L2H;
          w_cnt_nxt   = '0;
        end
      end
      ST_L2H: begin
        if (!r_s_sync) begin
          w_state_nxt = ST_LOW;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = ST_HIGH;
          w_cnt_nxt   = '0;
          w_rise_nxt  = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      ST_HIGH: begin
        if (!r_s_sync) begin
          w_state_nxt = ST_H2L;
          w_cnt_nxt   = '0;
        end
      end
      ST_H2L: begin
        if (r_s_sync) begin
          w_state_nxt = ST_HIGH;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = ST_LOW;
          w_cnt_nxt   = '0;
          w_fall_nxt  = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = ST_LOW;
        w_cnt_nxt   = '0;
      end
    endcase
    w_out_nxt = (w_state_nxt == ST_HIGH) || (w_state_nxt == ST_H2L);
  end

  assign debounce_out = r_out;
  assign rise_pulse   = r_rise;
  assign fall_pulse   = r_fall;

endmodule
